// File: rtl/freq_ring_sequencer.sv
// freq_ring_sequencer: pops frequency indices from the tone ring, scales them
// to DDS phase increments and streams them out as channel-tagged frames.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no reads issued, waiting for enable
// RUN    | issuing ring reads, one channel per read, frames of N_CH
// DRAIN  | frame boundary reached with enable low; emptying FIFO/in-flight
module freq_ring_sequencer #(
  parameter int N_CH   = 16,
  parameter int IDX_W  = 14,
  parameter int SHIFT  = 10,
  parameter int PINC_W = 24
) (
  input  logic                      dev_clk,
  input  logic                      dev_rstn,
  input  logic                      enable,
  output logic                      rd_en_ring,
  input  logic [IDX_W-1:0]          dout_ring,
  output logic [PINC_W-1:0]         m_axis_tdata,
  output logic [$clog2(N_CH)-1:0]   m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic [31:0]               frame_count
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int WIDE_W = (IDX_W + SHIFT > PINC_W) ? (IDX_W + SHIFT) : PINC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              inflight_q, inflight_d;
  logic [CH_W-1:0]   fl_ch_q, fl_ch_d;
  logic              fl_last_q, fl_last_d;
  logic [PINC_W-1:0] pinc_mem_q [2];
  logic [PINC_W-1:0] pinc_mem_d [2];
  logic [CH_W-1:0]   ch_mem_q [2];
  logic [CH_W-1:0]   ch_mem_d [2];
  logic [1:0]        last_mem_q, last_mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       frame_count_q, frame_count_d;

  logic              pop;
  logic              stop_req;
  logic [1:0]        occ_after_pop;
  logic              credit_ok;
  logic [WIDE_W-1:0] pinc_wide;
  logic [PINC_W-1:0] pinc_new;

  // Issue control: the slot freed by this cycle's transfer counts as free,
  // which keeps reads back-to-back with tready high and still bounds the
  // FIFO plus in-flight read to two entries.
  always_comb begin
    pop           = (count_q != 2'd0) && m_axis_tready;
    stop_req      = !enable && (ch_q == '0);
    occ_after_pop = count_q - {1'b0, pop};
    credit_ok     = (occ_after_pop + {1'b0, inflight_q}) < 2'd2;
    rd_en_ring    = (state_q == S_RUN) && !stop_req && credit_ok;
    pinc_wide     = WIDE_W'(dout_ring) << SHIFT;
    pinc_new      = pinc_wide[PINC_W-1:0];
  end

  // Next-state logic for FSM, channel counter, FIFO and frame counter.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    inflight_d    = rd_en_ring;
    fl_ch_d       = fl_ch_q;
    fl_last_d     = fl_last_q;
    pinc_mem_d    = pinc_mem_q;
    ch_mem_d      = ch_mem_q;
    last_mem_d    = last_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + {1'b0, inflight_q} - {1'b0, pop};
    frame_count_d = frame_count_q;

    if (rd_en_ring) begin
      fl_ch_d   = ch_q;
      fl_last_d = (ch_q == CH_W'(N_CH - 1));
      ch_d      = ch_q + 1'b1;
    end

    if (inflight_q) begin
      pinc_mem_d[wr_ptr_q] = pinc_new;
      ch_mem_d[wr_ptr_q]   = fl_ch_q;
      last_mem_d[wr_ptr_q] = fl_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (last_mem_q[rd_ptr_q]) begin
        frame_count_d = frame_count_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
          ch_d    = '0;
        end
      end
      S_RUN: begin
        if (stop_req) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset also discards any ring read in flight.
  always_ff @(posedge dev_clk or negedge dev_rstn) begin
    if (!dev_rstn) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      inflight_q    <= 1'b0;
      fl_ch_q       <= '0;
      fl_last_q     <= 1'b0;
      pinc_mem_q    <= '{default: '0};
      ch_mem_q      <= '{default: '0};
      last_mem_q    <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      frame_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      inflight_q    <= inflight_d;
      fl_ch_q       <= fl_ch_d;
      fl_last_q     <= fl_last_d;
      pinc_mem_q    <= pinc_mem_d;
      ch_mem_q      <= ch_mem_d;
      last_mem_q    <= last_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Stream outputs come straight from the FIFO head.
  always_comb begin
    m_axis_tdata  = pinc_mem_q[rd_ptr_q];
    m_axis_tuser  = ch_mem_q[rd_ptr_q];
    m_axis_tlast  = last_mem_q[rd_ptr_q];
    m_axis_tvalid = (count_q != 2'd0);
    busy          = (state_q != S_IDLE);
    frame_count   = frame_count_q;
  end

endmodule

// File: tb/tb_freq_ring_sequencer.sv
module tb_freq_ring_sequencer;

  localparam int N_CH   = 16;
  localparam int IDX_W  = 14;
  localparam int SHIFT  = 10;
  localparam int PINC_W = 24;

  logic               dev_clk = 1'b0;
  logic               dev_rstn;
  logic               enable;
  logic               rd_en_ring;
  logic [IDX_W-1:0]   dout_ring = '0;
  logic [PINC_W-1:0]  m_axis_tdata;
  logic [3:0]         m_axis_tuser;
  logic               m_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               busy;
  logic [31:0]        frame_count;

  // second instance with a narrower phase increment, fed a constant index
  logic               enable2;
  logic               rd_en2;
  logic [IDX_W-1:0]   dout2;
  logic [19:0]        tdata2;
  logic [3:0]         tuser2;
  logic               tlast2;
  logic               tvalid2;
  logic               tready2;
  logic               busy2;
  logic [31:0]        fc2;

  always #5 dev_clk = ~dev_clk;

  freq_ring_sequencer #(.N_CH(N_CH), .IDX_W(IDX_W), .SHIFT(SHIFT), .PINC_W(PINC_W)) dut (
    .dev_clk(dev_clk), .dev_rstn(dev_rstn), .enable(enable),
    .rd_en_ring(rd_en_ring), .dout_ring(dout_ring),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .frame_count(frame_count)
  );

  freq_ring_sequencer #(.N_CH(N_CH), .IDX_W(IDX_W), .SHIFT(SHIFT), .PINC_W(20)) dut20 (
    .dev_clk(dev_clk), .dev_rstn(dev_rstn), .enable(enable2),
    .rd_en_ring(rd_en2), .dout_ring(dout2),
    .m_axis_tdata(tdata2), .m_axis_tuser(tuser2), .m_axis_tlast(tlast2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
    .busy(busy2), .frame_count(fc2)
  );

  // recirculating ring: data valid one cycle after the pop request
  logic [IDX_W-1:0] ring_mem [64];
  logic [5:0]       ring_ptr = '0;
  always @(posedge dev_clk) begin
    if (rd_en_ring) begin
      dout_ring <= ring_mem[ring_ptr];
      ring_ptr  <= ring_ptr + 6'd1;
    end
  end

  // reference model state
  logic [IDX_W-1:0] exp_q [$];
  int               rd_issued;
  int               beats;
  logic             prev_rd;
  logic             prev_stall;
  logic [PINC_W-1:0] prev_data;
  logic [3:0]       prev_user;
  logic             prev_last;
  logic [31:0]      model_frames;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    rd_issued    = 0;
    beats        = 0;
    prev_rd      = 1'b0;
    prev_stall   = 1'b0;
    model_frames = 32'd0;
  endtask

  // Monitor: stream contents, ordering, stability, credit bound, frame count.
  always @(negedge dev_clk) begin
    int          outst;
    int          fifo_m;
    logic        xfer;
    logic [IDX_W-1:0] v;
    longint      exp_data;
    int          exp_ch;
    if (dev_rstn) begin
      outst  = rd_issued - beats;
      fifo_m = outst - (prev_rd ? 1 : 0);
      check("tvalid_vs_occupancy", m_axis_tvalid, fifo_m > 0);
      check("frame_count", frame_count, model_frames);
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_payload", {m_axis_tdata, m_axis_tuser, m_axis_tlast},
              {prev_data, prev_user, prev_last});
      end
      xfer = m_axis_tvalid && m_axis_tready;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          v        = exp_q.pop_front();
          exp_data = (longint'(v) * (longint'(1) << SHIFT)) % (longint'(1) << PINC_W);
          exp_ch   = beats % N_CH;
          check("beat_tdata", m_axis_tdata, exp_data);
          check("beat_tuser", m_axis_tuser, exp_ch);
          check("beat_tlast", m_axis_tlast, exp_ch == N_CH - 1);
          if (exp_ch == N_CH - 1) model_frames = model_frames + 32'd1;
        end
        beats++;
      end
      check("credit_bound", (outst - int'(xfer) + int'(rd_en_ring)) <= 2, 1);
      if (rd_en_ring) begin
        exp_q.push_back(ring_mem[ring_ptr]);
        rd_issued++;
      end
      prev_rd    = rd_en_ring;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_last  = m_axis_tlast;
      if (tvalid2) check("pinc_w20_trunc", tdata2, 20'hFFC00);
    end
  end

  task automatic wait_beats(input int target, input int bound);
    int i;
    i = 0;
    while (beats < target && i < bound) begin
      @(negedge dev_clk); #1;
      i++;
    end
    check("wait_beats", beats >= target, 1);
  endtask

  task automatic wait_issue(input int ch, input int bound);
    int   i;
    logic found;
    i     = 0;
    found = 1'b0;
    while (!found && i < bound) begin
      @(negedge dev_clk); #1;
      found = rd_en_ring && (((rd_issued - 1) % N_CH) == ch);
      i++;
    end
    check("wait_issue", found, 1);
  endtask

  task automatic wait_idle_random(input int bound);
    int i;
    i = 0;
    while (busy && i < bound) begin
      @(posedge dev_clk); #1;
      m_axis_tready = 1'($urandom % 2);
      i++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en_ring, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tuser"}, m_axis_tuser, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_tvalid_w20"}, tvalid2, 0);
  endtask

  initial begin
    int frames_at_drop;
    dev_rstn      = 1'b0;
    enable        = 1'b0;
    m_axis_tready = 1'b0;
    enable2       = 1'b0;
    tready2       = 1'b1;
    dout2         = 14'h3FFF;
    for (int i = 0; i < 64; i++) begin
      ring_mem[i] = (i < 16) ? IDX_W'(i) : IDX_W'($urandom_range(0, 16383));
    end
    ring_mem[16] = 14'h3FFF;
    ring_mem[40] = 14'h3FFF;
    clear_model();

    // reset state
    repeat (3) @(posedge dev_clk);
    #1 check_zero_outputs("reset");

    // first frame: startup latency and back-to-back throughput
    @(posedge dev_clk); #1;
    dev_rstn      = 1'b1;
    enable        = 1'b1;
    enable2       = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge dev_clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge dev_clk);
      check("first_frame_rd_en", rd_en_ring, 1);
      if (i == 0) check("run_busy", busy, 1);
      if (i < 2)  check("startup_tvalid_low", m_axis_tvalid, 0);
      if (i == 2) check("startup_tvalid_high", m_axis_tvalid, 1);
      if (i >= 2) check("zero_bubble_tvalid", m_axis_tvalid, 1);
    end
    wait_beats(16, 100);
    @(negedge dev_clk);
    check("first_frame_count", frame_count, 1);

    // backpressure: alternating, long stall, then random
    for (int i = 0; i < 40; i++) begin
      @(posedge dev_clk); #1;
      m_axis_tready = i[0];
    end
    @(posedge dev_clk); #1;
    m_axis_tready = 1'b0;
    repeat (20) @(posedge dev_clk);
    @(negedge dev_clk); #1;
    check("stall_rd_en_stopped", rd_en_ring, 0);
    check("stall_tvalid_held", m_axis_tvalid, 1);
    check("stall_outstanding", rd_issued - beats, 2);
    for (int i = 0; i < 100; i++) begin
      @(posedge dev_clk); #1;
      m_axis_tready = 1'($urandom % 2);
    end

    // enable dropped mid-frame: the frame completes, then drain to idle
    @(posedge dev_clk); #1;
    m_axis_tready = 1'b1;
    wait_issue(5, 200);
    @(posedge dev_clk); #1;
    enable         = 1'b0;
    frames_at_drop = int'(model_frames);
    wait_idle_random(500);
    @(negedge dev_clk); #1;
    check("drain_frame_count", frame_count, frames_at_drop + 1);
    check("drain_whole_frames", rd_issued % N_CH, 0);
    check("drain_all_beats_out", beats, rd_issued);
    check("drain_tvalid", m_axis_tvalid, 0);
    repeat (5) @(posedge dev_clk);
    @(negedge dev_clk);
    check("idle_rd_en", rd_en_ring, 0);
    check("idle_busy", busy, 0);

    // reset mid-frame with a read in flight
    @(posedge dev_clk); #1;
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    wait_issue(7, 200);
    @(posedge dev_clk); #1;
    dev_rstn = 1'b0;
    clear_model();
    #1 check_zero_outputs("midreset");
    repeat (3) @(posedge dev_clk);
    #1 dev_rstn = 1'b1;
    wait_beats(20, 200);
    for (int i = 0; i < 60; i++) begin
      @(posedge dev_clk); #1;
      m_axis_tready = 1'($urandom % 2);
    end
    @(posedge dev_clk); #1;
    enable = 1'b0;
    wait_idle_random(500);

    // frame counter wrap
    @(posedge dev_clk); #1;
    force dut.frame_count_q = 32'hFFFF_FFFF;
    model_frames = 32'hFFFF_FFFF;
    @(posedge dev_clk); #1;
    release dut.frame_count_q;
    @(negedge dev_clk);
    check("preset_frame_count", frame_count, 32'hFFFF_FFFF);
    @(posedge dev_clk); #1;
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    begin
      int i;
      i = 0;
      while (model_frames != 32'd0 && i < 200) begin
        @(negedge dev_clk); #1;
        i++;
      end
    end
    @(negedge dev_clk);
    check("wrap_frame_count", frame_count, 0);
    @(posedge dev_clk); #1;
    enable = 1'b0;
    wait_idle_random(500);
    @(negedge dev_clk);
    check("after_wrap_frame_count", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
